// File: rtl/cpu_pkg.sv
// Shared CPU constants: default register-file geometry and the hardwired-zero index.
package cpu_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;
    localparam int ZERO_IDX   = 0;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, RAW/WAW busy and issue-stall generation.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_vld,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     iss_stall
);
    localparam int DEPTH = depth_of(ADDR_W);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic             dst_busy;
    logic             iss_acc;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == ADDR_W'(ZERO_IDX));
    endfunction

    // A writeback landing this cycle resolves the hazard on its index.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a          = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_busy[k] = rd_vld[k] && pending_q[a] && !(wr_en && wr_addr == a) && !is_zero(a);
    end

    assign dst_busy  = pending_q[iss_addr] && !(wr_en && wr_addr == iss_addr) && !is_zero(iss_addr);
    assign iss_stall = iss_en && ((|rd_busy) || dst_busy);
    assign iss_acc   = iss_en && !iss_stall && !is_zero(iss_addr);

    // Issue set is applied last so a new producer wins over a same-edge clear or flush.
    always_comb begin
        pending_d = pending_q;
        if (flush) begin
            pending_d = '0;
        end else if (wr_en) begin
            pending_d[wr_addr] = 1'b0;
        end
        if (iss_acc) begin
            pending_d[iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pending_d[ZERO_IDX] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write-through bypass, hardwired zero register
// and a pending-write scoreboard for issue hazard detection.
module reg_file_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_vld,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_stall,
    input  logic                     flush
);
    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == ADDR_W'(ZERO_IDX));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && !is_zero(wr_addr)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Reset forces zero even while a bypassed write is presented.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_data[k*DATA_W +: DATA_W] =
            (!rst_n || is_zero(a))    ? '0      :
            (wr_en && wr_addr == a)   ? wr_data :
                                        mem_q[a];
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_vld    (rd_vld),
        .rd_addr   (rd_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .flush     (flush),
        .rd_busy   (rd_busy),
        .iss_stall (iss_stall)
    );
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and randomized checks of reg_file_sb (3 read ports) against a behavioural model.
module tb_reg_file_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    rd_vld;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
    logic             iss_stall;
    logic             flush;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] m_mem  [32];
    bit            m_pend [32];

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_vld    (rd_vld),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .iss_stall (iss_stall),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] port_addr(input int k);
        return rd_addr[k*AW +: AW];
    endfunction

    // Model: what the register file should present given current inputs and model state.
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (!rst_n || a == 0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    function automatic bit hazard(input logic [AW-1:0] a);
        return rst_n && a != 0 && m_pend[a] && !(wr_en && wr_addr == a);
    endfunction

    function automatic logic [NR-1:0] exp_busy();
        logic [NR-1:0] b;
        for (int k = 0; k < NR; k++) b[k] = rd_vld[k] && hazard(port_addr(k));
        return b;
    endfunction

    function automatic logic exp_stall();
        return iss_en && ((exp_busy() != '0) || hazard(iss_addr));
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < NR; k++)
            chk($sformatf("%s_data%0d", tag, k), rd_data[k*DW +: DW], exp_rd(port_addr(k)));
        chk({tag, "_busy"}, DW'(rd_busy), DW'(exp_busy()));
        chk({tag, "_stall"}, DW'(iss_stall), DW'(exp_stall()));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic tick();
        bit acc;
        @(posedge clk);
        if (rst_n) begin
            acc = iss_en && !exp_stall();
            if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            end else if (wr_en) begin
                m_pend[wr_addr] = 1'b0;
            end
            if (acc && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        rd_vld = '0; wr_en = 0; iss_en = 0; flush = 0;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic probe(input string tag, input logic [AW-1:0] idx, input bit exp);
        idle();
        rd_vld = 3'b001;
        set_rd(0, idx);
        #1;
        chk(tag, DW'(rd_busy[0]), DW'(exp));
    endtask

    initial begin
        rst_n = 0; rd_vld = '0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
        iss_en = 0; iss_addr = '0; flush = 0;
        model_reset();
        #12;
        rd_vld = 3'b111; rd_addr = {5'd7, 5'd3, 5'd1};
        check_all("reset");
        rst_n = 1;
        tick();

        // Mid-run reset while writing r7.
        idle(); wr_en = 1; wr_addr = 7; wr_data = 32'h1234; tick();
        rst_n = 0; model_reset();
        wr_en = 1; wr_addr = 7; wr_data = 32'hDEADBEEF; set_rd(0, 7); set_rd(1, 0);
        #1; chk("rst_r7", rd_data[0 +: DW], 32'h0);
        tick();
        rst_n = 1;
        #1; chk("rel_bypass_r7", rd_data[0 +: DW], 32'hDEADBEEF);
        tick();
        wr_en = 0;
        #1; chk("stored_r7", rd_data[0 +: DW], 32'hDEADBEEF);
        wr_en = 1; wr_addr = 0;
        #1; chk("r0_bypass", rd_data[DW +: DW], 32'h0);
        tick();
        idle(); iss_en = 1; iss_addr = 0; tick();
        wr_en = 0; #1; chk("r0_stored", rd_data[DW +: DW], 32'h0);
        probe("r0_pend", 0, 0);

        // Bypass on two ports.
        idle(); set_rd(0, 3); set_rd(1, 3);
        #1; chk("byp_prior0", rd_data[0 +: DW], 32'h0); chk("byp_prior1", rd_data[DW +: DW], 32'h0);
        wr_en = 1; wr_addr = 3; wr_data = 5;
        #1; chk("byp0", rd_data[0 +: DW], 32'd5); chk("byp1", rd_data[DW +: DW], 32'd5);
        tick();

        // RAW on r5.
        idle(); iss_en = 1; iss_addr = 5;
        #1; chk("raw_iss", DW'(iss_stall), 0);
        tick();
        idle(); rd_vld = 3'b001; set_rd(0, 5); iss_en = 1; iss_addr = 10;
        #1; chk("raw_busy", DW'(rd_busy[0]), 1); chk("raw_stall", DW'(iss_stall), 1);
        tick();
        wr_en = 1; wr_addr = 5; wr_data = 8;
        #1; chk("raw_res_busy", DW'(rd_busy[0]), 0); chk("raw_res_stall", DW'(iss_stall), 0);
        chk("raw_res_data", rd_data[0 +: DW], 32'd8);
        tick();

        // WAW and same-edge clear/set on r9.
        idle(); iss_en = 1; iss_addr = 9; tick();
        #1; chk("waw_stall", DW'(iss_stall), 1);
        tick();
        wr_en = 1; wr_addr = 9; wr_data = 32'h99;
        #1; chk("waw_res_stall", DW'(iss_stall), 0);
        tick();
        probe("waw_pend9", 9, 1);

        // Flush with accepted issue and simultaneous write.
        idle(); iss_en = 1; iss_addr = 2; tick();
        iss_addr = 4; tick();
        iss_addr = 6; tick();
        probe("fl_pre2", 2, 1); probe("fl_pre4", 4, 1); probe("fl_pre6", 6, 1);
        idle(); wr_en = 1; wr_addr = 4; wr_data = 32'h44; tick();
        idle(); flush = 1; wr_en = 1; wr_addr = 2; wr_data = 11; iss_en = 1; iss_addr = 4;
        #1; chk("fl_stall", DW'(iss_stall), 0);
        tick();
        probe("fl_p2", 2, 0); probe("fl_p4", 4, 1); probe("fl_p6", 6, 0);
        probe("fl_p9", 9, 0); probe("fl_p10", 10, 0);
        set_rd(1, 2); #1; chk("fl_r2", rd_data[DW +: DW], 32'd11);

        // Multi-port: ports read r1, r2, r1 with r2 pending.
        idle(); iss_en = 1; iss_addr = 2; tick();
        idle(); rd_vld = 3'b111; set_rd(0, 1); set_rd(1, 2); set_rd(2, 1);
        iss_en = 1; iss_addr = 12;
        #1; chk("mp_busy", DW'(rd_busy), 32'b010); chk("mp_stall", DW'(iss_stall), 1);
        rd_vld = 3'b101;
        #1; chk("mp_drop_stall", DW'(iss_stall), 0); chk("mp_drop_busy", DW'(rd_busy), 0);
        check_all("mp");
        tick();

        // Randomized traffic over a small index range to provoke hazards.
        for (int c = 0; c < 400; c++) begin
            rst_n    = ($urandom_range(0, 79) != 0);
            if (!rst_n) model_reset();
            rd_vld   = NR'($urandom);
            for (int k = 0; k < NR; k++) set_rd(k, AW'($urandom_range(0, 7)));
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = AW'($urandom_range(0, 7));
            wr_data  = $urandom;
            iss_en   = ($urandom_range(0, 1) == 0);
            iss_addr = AW'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 15) == 0);
            #1;
            check_all($sformatf("rnd%0d", c));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised, multi-read-port register file for the pipelined CPU, with a per-register pending-write scoreboard.
- Sits between decode/issue (reads, destination marking) and writeback (writes).
- Adds to the single-port design:
  - asynchronous active-low reset;
  - configurable width, depth and read-port count;
  - hardwired zero register;
  - same-cycle write-through bypass;
  - RAW/WAW hazard detection with an issue-stall output.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1 register 0 reads as 0, is never written and is never pending.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_vld  in  NUM_RD  per-port read-request valid (used for hazard check only).
- rd_addr  in  NUM_RD*ADDR_W  packed read indices, port k at [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  port k source has an outstanding writer not resolved this cycle.
- wr_en  in  1  writeback write enable.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback data.
- iss_en  in  1  instruction with a destination is attempting issue.
- iss_addr  in  ADDR_W  destination index of issuing instruction.
- iss_stall  out  1  issue must be held this cycle.
- flush  in  1  synchronous clear of all pending bits (pipeline flush).

Behaviour:
- Reset (rst_n low, asynchronous): all 2**ADDR_W registers = 0, all pending bits = 0. Outputs during reset: rd_data = 0, rd_busy = 0, iss_stall = 0. Release takes effect at the next rising clk. No initial preload in RTL; benches preload via writes.
- Reads: combinational, zero latency.
  - rd_data[k] = wr_data when wr_en && wr_addr == rd_addr[k] && !(ZERO_REG && rd_addr[k] == 0) (write-through bypass).
  - Otherwise rd_data[k] = stored register.
  - Index 0 always reads 0 when ZERO_REG = 1.
- Write: on rising clk when wr_en, mem[wr_addr] <= wr_data. A write to index 0 is dropped when ZERO_REG = 1.
- Scoreboard (pending[i], one bit per register):
  - rd_busy[k] = rd_vld[k] && pending[rd_addr[k]] && !(wr_en && wr_addr == rd_addr[k]); forced 0 for index 0 when ZERO_REG = 1.
  - dst_busy = pending[iss_addr] && !(wr_en && wr_addr == iss_addr); forced 0 for index 0.
  - iss_stall = iss_en && (|rd_busy || dst_busy). This is combinational, and a WAW on a pending destination stalls.
  - Issue is accepted when iss_en && !iss_stall. An accepted issue sets pending[iss_addr] at the edge; index 0 is never set.
  - wr_en clears pending[wr_addr] at the edge.
- Simultaneous events at one edge:
  - Write and accepted issue to the same index: the bit ends set (new producer wins).
  - flush with an accepted issue: all bits clear except pending[iss_addr], which ends set. flush takes priority over writeback clears, which are redundant under flush.
  - flush with wr_en: the write to mem still occurs; only the scoreboard is cleared.
- Write to a non-pending register: legal; it updates mem and leaves pending unchanged (0).
- Reset mid-operation: immediate clear of mem and pending. In-flight writes are lost.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W / ADDR_W defaults;
  - the ZERO_IDX constant;
  - a localparam for depth derivation.
- One sub-module, reg_scoreboard. It holds the pending-bit vector, set/clear/flush logic and busy/stall generation, and is parametrised by ADDR_W and NUM_RD.
- The top level holds the storage array, the bypass muxes, and the instantiation of reg_scoreboard.

Test Plan:
- Reset and zero register:
  - Assert rst_n = 0 mid-run, then write 0xDEADBEEF to r7 and to r0.
  - Required: r7 reads 0 during reset. After release, r7 reads 0xDEADBEEF the same cycle via bypass and next cycle from storage. r0 stays 0 with pending[0] = 0.
- Bypass:
  - Set rd_addr[0] = rd_addr[1] = 3, then write r3 = 5 with wr_en = 1.
  - Required: both ports show 5 in the same cycle. With wr_en = 0 they show the prior value 0.
- RAW hazard:
  - Issue dst r5 (accepted). Next cycle, read r5 with rd_vld = 1 and iss_en = 1.
  - Required: rd_busy[0] = 1 and iss_stall = 1.
  - Then write r5 = 8: in that cycle rd_busy[0] = 0, iss_stall = 0, rd_data = 8.
- WAW and same-edge set/clear:
  - With r9 pending, issue dst r9 → iss_stall = 1.
  - Then pulse wr_en(r9) together with iss_en(r9) → iss_stall = 0, and pending[9] = 1 after the edge.
- Flush:
  - Set r2, r4 and r6 pending, then flush with an accepted issue to r4.
  - Required after the edge: only pending[4] = 1. A simultaneous write of r2 = 11 stores 11.
- Multi-port:
  - Use NUM_RD = 3 with ports reading r1, r2, r1. r2 is pending and r1 is not.
  - Required: rd_busy = 3'b010, iss_stall = 1. Drop rd_vld[1] → iss_stall = 0.
